fp_sdiv_seq: RTL

Sequential signed fixed-point divider computing dina/dinb in two's complement, one quotient bit per enabled cycle by restoring division on magnitudes. It sits beside the LUT/Newton-Raphson reciprocal in the arithmetic library. It takes the same WI.WF signed input format and produces a WIO.WFO signed result. It trades latency for exact, truncated quotients with a start/valid handshake, and applies the same divide-by-zero saturation policy as the reciprocal.

---
 rtl/fp_sdiv_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fp_sdiv_seq.sv
// rtl/fp_sdiv_seq.sv - sequential signed fixed-point divider (restoring, one quotient bit per enabled cycle)
// Truncating quotient with divide-by-zero and overflow saturation; start/valid handshake.
module fp_sdiv_seq #(
  parameter int WI  = 8,
  parameter int WF  = 8,
  parameter int WL  = WI + WF,
  parameter int WIO = WL,
  parameter int WFO = WF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 CE,
  input  logic                 start,
  input  logic [WL-1:0]        dina,
  input  logic [WL-1:0]        dinb,
  output logic                 ready,
  output logic                 dout_valid,
  output logic [WIO+WFO-1:0]   dout,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int WN = WL + WFO;
  localparam int WO = WIO + WFO;
  localparam int CW = $clog2(WN);
  localparam int WX = ((WN > WO) ? WN : WO) + 1;

  localparam logic [WO-1:0] MAX_POS = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MIN_NEG = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_sign_q;
  logic            r_sign_a;
  logic [WL-1:0]   r_b;
  logic [WN-1:0]   r_n;
  logic [WL:0]     r_rem;
  logic [WN-1:0]   r_q;
  logic            r_ready;
  logic            r_valid;
  logic [WO-1:0]   r_dout;
  logic            r_div_zero;
  logic            r_ovf;

  logic [WL-1:0]   w_abs_a;
  logic [WL-1:0]   w_abs_b;
  logic [WL+1:0]   w_shift;
  logic [WL+1:0]   w_diff;
  logic [WX-1:0]   w_q_ext;
  logic [WX-1:0]   w_m;
  logic [WO-1:0]   w_q_o;
  logic [WO-1:0]   w_neg;

  // Negating the most negative input wraps to 2^(WL-1), which is its exact unsigned magnitude.
  assign w_abs_a = dina[WL-1] ? (~dina + 1'b1) : dina;
  assign w_abs_b = dinb[WL-1] ? (~dinb + 1'b1) : dinb;

  // Remainder stays below the divisor, so the top bit of the difference is a valid sign.
  assign w_shift = {r_rem, r_n[WN-1]};
  assign w_diff  = w_shift - {2'b00, r_b};

  assign w_q_ext = WX'(r_q);
  assign w_m     = WX'(1) << (WO - 1);
  assign w_q_o   = WO'(r_q);
  assign w_neg   = ~w_q_o + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sign_q   <= 1'b0;
      r_sign_a   <= 1'b0;
      r_b        <= '0;
      r_n        <= '0;
      r_rem      <= '0;
      r_q        <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_dout     <= '0;
      r_div_zero <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (CE) begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign_q <= dina[WL-1] ^ dinb[WL-1];
            r_sign_a <= dina[WL-1];
            r_b      <= w_abs_b;
            r_n      <= WN'(w_abs_a) << WFO;
            r_rem    <= '0;
            r_q      <= '0;
            r_cnt    <= CW'(WN - 1);
            r_ready  <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_n <= r_n << 1;
          if (!w_diff[WL+1]) begin
            r_rem <= w_diff[WL:0];
            r_q   <= {r_q[WN-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WL:0];
            r_q   <= {r_q[WN-2:0], 1'b0};
          end
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        FIX: begin
          r_div_zero <= 1'b0;
          r_ovf      <= 1'b0;
          if (r_b == '0) begin
            r_div_zero <= 1'b1;
            r_dout     <= r_sign_a ? MIN_NEG : MAX_POS;
          end else if (!r_sign_q) begin
            if (w_q_ext > (w_m - 1'b1)) begin
              r_dout <= MAX_POS;
              r_ovf  <= 1'b1;
            end else begin
              r_dout <= w_q_o;
            end
          end else begin
            // Magnitude exactly M maps onto the most negative code without saturating.
            if (w_q_ext > w_m) begin
              r_dout <= MIN_NEG;
              r_ovf  <= 1'b1;
            end else begin
              r_dout <= w_neg;
            end
          end
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign dout_valid = r_valid;
  assign dout       = r_dout;
  assign div_zero   = r_div_zero;
  assign ovf        = r_ovf;

endmodule
